// File: rtl/uart_baud_rate_generator.sv
// Free-running baud-rate tick generator for the APB UART.
// Divides clk by DIVISOR = CLK_FREQ_HZ / BAUD_RATE (truncated) and emits a registered,
// single-cycle baud_tick once per bit period. The divisor is fixed at elaboration.
// Optional build macro UART_BAUD_OVERSAMPLE_EN adds an independent 16x os_tick strobe
// with period OS_DIV = DIVISOR / 16.
module uart_baud_rate_generator #(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned BAUD_RATE   = 115200
) (
   input  logic clk,
   input  logic rst_n,
   output logic baud_tick
`ifdef UART_BAUD_OVERSAMPLE_EN
   ,
   output logic os_tick
`endif
);

   // Guard the division so a zero baud rate reaches the elaboration check below
   // instead of failing inside a constant expression.
   localparam int unsigned DIVISOR = (BAUD_RATE == 0) ? 0 : (CLK_FREQ_HZ / BAUD_RATE);
   localparam int unsigned CNT_W   = (DIVISOR <= 2) ? 1 : $clog2(DIVISOR);

   // Achieved rate and its absolute deviation from the target, in 64-bit to keep the
   // percentage comparison free of overflow.
   localparam longint unsigned ACTUAL_RATE =
      (DIVISOR == 0) ? 64'd0 : (longint'(CLK_FREQ_HZ) / longint'(DIVISOR));
   localparam longint unsigned RATE_DELTA  =
      (ACTUAL_RATE > longint'(BAUD_RATE)) ? (ACTUAL_RATE - longint'(BAUD_RATE))
                                          : (longint'(BAUD_RATE) - ACTUAL_RATE);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DIVISOR - 1);

   // ---------------------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ---------------------------------------------------------------------------------------
   if (BAUD_RATE == 0) begin : g_err_baud_zero
      $error("uart_baud_rate_generator: BAUD_RATE must be non-zero");
   end

   if (DIVISOR < 2) begin : g_err_div_small
      $error("uart_baud_rate_generator: DIVISOR = CLK_FREQ_HZ / BAUD_RATE must be >= 2");
   end

   if ((BAUD_RATE != 0) && (RATE_DELTA * 100 > longint'(BAUD_RATE) * 2)) begin : g_err_rate
      $error("uart_baud_rate_generator: achieved baud rate deviates more than 2%% from target");
   end

   // ---------------------------------------------------------------------------------------
   // Baud counter
   // ---------------------------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             baud_tick_q, baud_tick_d;

   // Next-state: wrap at DIVISOR-1 and strobe; any out-of-range value reloads zero.
   always_comb begin
      cnt_d       = cnt_q + CNT_W'(1);
      baud_tick_d = 1'b0;
      if (cnt_q == CntMax) begin
         cnt_d       = '0;
         baud_tick_d = 1'b1;
      end else if (cnt_q > CntMax) begin
         cnt_d       = '0;
      end
   end

   // Counter and tick registers; reset discards any partial count immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         baud_tick_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         baud_tick_q <= baud_tick_d;
      end
   end

   assign baud_tick = baud_tick_q;

`ifdef UART_BAUD_OVERSAMPLE_EN
   // ---------------------------------------------------------------------------------------
   // Oversample counter, free-running and unaligned with the baud counter
   // ---------------------------------------------------------------------------------------
   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned OS_DIV     = DIVISOR / OVERSAMPLE;
   localparam int unsigned OS_W       = (OS_DIV <= 2) ? 1 : $clog2(OS_DIV);

   localparam logic [OS_W-1:0] OsMax = OS_W'(OS_DIV - 1);

   if (OS_DIV < 2) begin : g_err_os_div_small
      $error("uart_baud_rate_generator: OS_DIV = DIVISOR / 16 must be >= 2");
   end

   logic [OS_W-1:0] os_cnt_q, os_cnt_d;
   logic            os_tick_q, os_tick_d;

   // Next-state: same wrap and recovery rules as the baud counter.
   always_comb begin
      os_cnt_d  = os_cnt_q + OS_W'(1);
      os_tick_d = 1'b0;
      if (os_cnt_q == OsMax) begin
         os_cnt_d  = '0;
         os_tick_d = 1'b1;
      end else if (os_cnt_q > OsMax) begin
         os_cnt_d  = '0;
      end
   end

   // Oversample counter and tick registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         os_cnt_q  <= '0;
         os_tick_q <= 1'b0;
      end else begin
         os_cnt_q  <= os_cnt_d;
         os_tick_q <= os_tick_d;
      end
   end

   assign os_tick = os_tick_q;
`endif

endmodule

// File: tb/tb_uart_baud_rate_generator.sv
// Self-checking bench for uart_baud_rate_generator: a default-rate instance and a small
// 1000 Hz / 100 baud instance share clock and reset. Expected ticks come from counting
// edges since reset release: a tick is due after edge n exactly when n is a positive
// multiple of the period.
module tb_uart_baud_rate_generator;

   localparam int unsigned CLK_HZ  = 50_000_000;
   localparam int unsigned BAUD    = 115200;
   localparam int unsigned DIV     = CLK_HZ / BAUD;   // 434
   localparam int unsigned S_DIV   = 1000 / 100;      // 10
`ifdef UART_BAUD_OVERSAMPLE_EN
   localparam int unsigned OS_DIV  = DIV / 16;        // 27
   localparam int unsigned S_OSDIV = 2;               // unused small-instance OS value
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic baud_tick;
   logic small_tick;
`ifdef UART_BAUD_OVERSAMPLE_EN
   logic os_tick;
   logic small_os_tick;
`endif

   int tests = 0;
   int fails = 0;
   int n     = 0;      // rising edges since the last reset release
   int first_big = -1;
   int tick_pos[$];

   always #5 clk = ~clk;

   uart_baud_rate_generator #(
      .CLK_FREQ_HZ (CLK_HZ),
      .BAUD_RATE   (BAUD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .baud_tick (baud_tick)
`ifdef UART_BAUD_OVERSAMPLE_EN
      ,
      .os_tick   (os_tick)
`endif
   );

`ifdef UART_BAUD_OVERSAMPLE_EN
   // The small instance has no valid oversample divisor, so it is built only without it.
   assign small_tick    = 1'b0;
   assign small_os_tick = 1'b0;
`else
   uart_baud_rate_generator #(
      .CLK_FREQ_HZ (1000),
      .BAUD_RATE   (100)
   ) dut_small (
      .clk       (clk),
      .rst_n     (rst_n),
      .baud_tick (small_tick)
   );
`endif

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, n);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic due(input int edges, input int unsigned period);
      return (edges > 0) && ((edges % period) == 0);
   endfunction

   // One clock edge, then compare every output against the edge-count model.
   task automatic step();
      @(posedge clk);
      #1;
      if (rst_n) n++;
      check_bit("baud_tick", baud_tick, rst_n && due(n, DIV));
`ifdef UART_BAUD_OVERSAMPLE_EN
      check_bit("os_tick", os_tick, rst_n && due(n, OS_DIV));
`else
      check_bit("small_tick", small_tick, rst_n && due(n, S_DIV));
`endif
      if (rst_n && baud_tick === 1'b1) begin
         if (first_big < 0) first_big = n;
         tick_pos.push_back(n);
      end
   endtask

   // Asynchronous reset between edges; outputs must drop without waiting for a clock.
   task automatic do_reset(input int edges);
      #2;
      rst_n = 1'b0;
      #1;
      check_bit("async_rst_baud", baud_tick, 1'b0);
`ifdef UART_BAUD_OVERSAMPLE_EN
      check_bit("async_rst_os", os_tick, 1'b0);
`else
      check_bit("async_rst_small", small_tick, 1'b0);
`endif
      n = 0;
      first_big = -1;
      repeat (edges) step();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int small_cnt;
      int target;

      // Held in reset for 5 edges: every output stays low.
      rst_n = 1'b0;
      repeat (5) step();
      @(negedge clk);
      rst_n = 1'b1;

      // First 1000 edges after release: small instance ticks exactly 100 times,
      // large instance first ticks at edge DIV.
      small_cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (small_tick === 1'b1) small_cnt++;
      end
`ifndef UART_BAUD_OVERSAMPLE_EN
      check_int("small_ticks_in_1000", small_cnt, 100);
`endif
      check_int("first_baud_edge", first_big, DIV);

      // Five consecutive pulses, four periods, each exactly DIV.
      tick_pos.delete();
      for (int i = 0; i < 6 * DIV && tick_pos.size() < 5; i++) step();
      check_int("pulse_count", tick_pos.size(), 5);
      for (int i = 1; i < tick_pos.size(); i++)
         check_int("baud_period", tick_pos[i] - tick_pos[i-1], DIV);

      // Reset around count 200: the next tick is DIV edges after release, not the remainder.
      target = $urandom_range(190, 210);
      for (int i = 0; i < 2 * DIV && (n % DIV) != target; i++) step();
      do_reset(3);
      repeat (DIV + 5) step();
      check_int("first_after_midreset", first_big, DIV);

      // Reset asserted while baud_tick is high must clear it at once.
      for (int i = 0; i < 2 * DIV && baud_tick !== 1'b1; i++) step();
      check_bit("tick_high_before_rst", baud_tick, 1'b1);
      do_reset(2);

      // Random run lengths interleaved with random-length resets.
      for (int k = 0; k < 6; k++) begin
         int len;
         len = $urandom_range(1, 1500);
         repeat (len) step();
         do_reset($urandom_range(1, 4));
      end
      repeat (DIV + 3) step();
      check_int("first_after_random", first_big, DIV);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
